// File: rtl/boron_dec_ctrl.sv
// boron_dec_ctrl: sequencing controller for an iterative block decryptor.
// Holds one 64-bit state register and a round counter, drives an external
// inverse-round datapath (rf_data_o -> rf_data_i) and a key store
// (rk_idx_o -> rk_i), and hands the plaintext out with a valid/ready handshake.
// Optional feature: define BORON_DEC_CTRL_ABORT_EN to add the abort_i input,
// which drops the block in flight and returns to IDLE.
module boron_dec_ctrl #(
    parameter int unsigned NUM_ROUNDS = 25
) (
    input  logic        clk_i,
    input  logic        rst_ni,
`ifdef BORON_DEC_CTRL_ABORT_EN
    input  logic        abort_i,
`endif
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] ct_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] pt_o,
    output logic [4:0]  rk_idx_o,
    input  logic [63:0] rk_i,
    output logic [63:0] rf_data_o,
    input  logic [63:0] rf_data_i,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Whitening key index used at accept time, and the first round index.
    localparam logic [4:0] LAST_IDX  = 5'(NUM_ROUNDS);
    localparam logic [4:0] FIRST_RND = 5'(NUM_ROUNDS - 1);

    logic [1:0]  fsm;
    logic [63:0] state;
    logic [4:0]  rnd;

    // FSM, state register and round counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm   <= ST_IDLE;
            state <= '0;
            rnd   <= '0;
        end else begin
`ifdef BORON_DEC_CTRL_ABORT_EN
            // Abort outranks both the round update and the output handshake.
            if (abort_i && (fsm != ST_IDLE)) begin
                fsm   <= ST_IDLE;
                state <= '0;
                rnd   <= '0;
            end else
`endif
            begin
                case (fsm)
                    ST_IDLE: begin
                        if (in_valid_i) begin
                            state <= ct_i ^ rk_i;
                            rnd   <= FIRST_RND;
                            fsm   <= ST_ROUND;
                        end
                    end
                    ST_ROUND: begin
                        state <= rf_data_i ^ rk_i;
                        // The counter parks at 0 for the final round.
                        if (rnd == 5'd0) begin
                            fsm <= ST_DONE;
                        end else begin
                            rnd <= rnd - 5'd1;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready_i) begin
                            fsm <= ST_IDLE;
                        end
                    end
                    default: begin
                        fsm <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Key index presented to the key store for the current state.
    always_comb begin
        rk_idx_o = LAST_IDX;
        case (fsm)
            ST_IDLE:  rk_idx_o = LAST_IDX;
            ST_ROUND: rk_idx_o = rnd;
            ST_DONE:  rk_idx_o = 5'd0;
            default:  rk_idx_o = LAST_IDX;
        endcase
    end

    // Handshake and status outputs decoded from the FSM state.
    always_comb begin
        in_ready_o  = (fsm == ST_IDLE);
        out_valid_o = (fsm == ST_DONE);
        busy_o      = (fsm != ST_IDLE);
        pt_o        = state;
        rf_data_o   = state;
    end

endmodule

// File: tb/tb_boron_dec_ctrl.sv
// Directed testbench for boron_dec_ctrl. The round datapath is an identity
// stub and the key store returns the index itself, so the plaintext is the
// ciphertext XORed with the XOR of all key indices.
module tb_boron_dec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ct;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] pt;
    logic [4:0]  rk_idx;
    logic [63:0] rk;
    logic [63:0] rf_out;
    logic [63:0] rf_in;
    logic        busy;
`ifdef BORON_DEC_CTRL_ABORT_EN
    logic        abort;
`endif

    // Second instance with a single round.
    logic        in_valid1;
    logic        in_ready1;
    logic [63:0] ct1;
    logic        out_valid1;
    logic        out_ready1;
    logic [63:0] pt1;
    logic [4:0]  rk_idx1;
    logic [63:0] rk1;
    logic [63:0] rf_out1;
    logic [63:0] rf_in1;
    logic        busy1;
`ifdef BORON_DEC_CTRL_ABORT_EN
    logic        abort1 = 1'b0;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    assign rk     = {59'd0, rk_idx};
    assign rf_in  = rf_out;
    assign rk1    = {59'd0, rk_idx1};
    assign rf_in1 = rf_out1;

    boron_dec_ctrl #(.NUM_ROUNDS(25)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
`ifdef BORON_DEC_CTRL_ABORT_EN
        .abort_i     (abort),
`endif
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ct_i        (ct),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pt_o        (pt),
        .rk_idx_o    (rk_idx),
        .rk_i        (rk),
        .rf_data_o   (rf_out),
        .rf_data_i   (rf_in),
        .busy_o      (busy)
    );

    boron_dec_ctrl #(.NUM_ROUNDS(1)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
`ifdef BORON_DEC_CTRL_ABORT_EN
        .abort_i     (abort1),
`endif
        .in_valid_i  (in_valid1),
        .in_ready_o  (in_ready1),
        .ct_i        (ct1),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready1),
        .pt_o        (pt1),
        .rk_idx_o    (rk_idx1),
        .rk_i        (rk1),
        .rf_data_o   (rf_out1),
        .rf_data_i   (rf_in1),
        .busy_o      (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  64'(in_ready),  64'd1);
        check({tag, "_ovld"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy),      64'd0);
        check({tag, "_pt"},   pt,             64'd0);
        check({tag, "_rf"},   rf_out,         64'd0);
        check({tag, "_idx"},  64'(rk_idx),    64'd25);
    endtask

    // One full block starting from IDLE at a falling edge; ends at the
    // falling edge of the following IDLE cycle.
    task automatic run_block(input logic [63:0] ct_val, input int unsigned stall,
                             input bit keep_valid, input logic [63:0] exp_pt);
        logic [63:0] model;
        check("idle_rdy", 64'(in_ready), 64'd1);
        check("idle_idx", 64'(rk_idx),   64'd25);
        ct        = ct_val;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        model     = ct_val ^ 64'd25;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (keep_valid) ct = ~ct_val;
            else            in_valid = 1'b0;
            check("rnd_idx",  64'(rk_idx),    64'(25 - k));
            check("rnd_data", rf_out,         model);
            check("rnd_ovld", 64'(out_valid), 64'd0);
            check("rnd_rdy",  64'(in_ready),  64'd0);
            check("rnd_busy", 64'(busy),      64'd1);
            model = model ^ 64'(25 - k);
        end
        @(negedge clk);
        check("done_ovld", 64'(out_valid), 64'd1);
        check("done_pt",   pt,             exp_pt);
        check("done_rdy",  64'(in_ready),  64'd0);
        check("done_idx",  64'(rk_idx),    64'd0);
        for (int s = 0; s < int'(stall); s++) begin
            @(negedge clk);
            check("hold_ovld", 64'(out_valid), 64'd1);
            check("hold_pt",   pt,             exp_pt);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_ovld", 64'(out_valid), 64'd0);
        check("post_busy", 64'(busy),      64'd0);
        check("post_rdy",  64'(in_ready),  64'd1);
        in_valid = keep_valid;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ct         = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        ct1        = '0;
        out_ready1 = 1'b0;
`ifdef BORON_DEC_CTRL_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Basic decrypt with immediate acceptance.
        run_block(64'h0123456789ABCDEF, 0, 1'b0, 64'h0123456789ABCDEE);

        // Consumer stalls for 10 cycles after completion.
        run_block(64'hFFFF0000AAAA5555, 10, 1'b0, 64'hFFFF0000AAAA5554);

        // in_valid held high: two back-to-back blocks, 27 cycles apart.
        run_block(64'h1111111111111110, 0, 1'b1, 64'h1111111111111111);
        run_block(64'hDEADBEEFCAFEF00D, 0, 1'b0, 64'hDEADBEEFCAFEF00C);

        // Reset pulse in the middle of a block.
        ct       = 64'h5A5A5A5A5A5A5A5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0)
                check("after_rst_quiet", {62'd0, busy, out_valid}, 64'd0);
        end
        check("after_rst_idle", 64'(in_ready), 64'd1);
        run_block(64'h0000000000000000, 0, 1'b0, 64'h0000000000000001);

`ifdef BORON_DEC_CTRL_ABORT_EN
        // Abort during the rounds discards the block.
        ct       = 64'h0F0F0F0F0F0F0F0F;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_reset_outputs("abort");
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0)
                check("abort_quiet", 64'(out_valid), 64'd0);
        end
        run_block(64'h0000000000000000, 0, 1'b0, 64'h0000000000000001);
`endif

        // Single-round instance.
        check("r1_idle_idx", 64'(rk_idx1), 64'd1);
        ct1       = '0;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("r1_rnd_idx",  64'(rk_idx1),    64'd0);
        check("r1_rnd_busy", 64'(busy1),      64'd1);
        check("r1_rnd_ovld", 64'(out_valid1), 64'd0);
        @(negedge clk);
        check("r1_done_ovld", 64'(out_valid1), 64'd1);
        check("r1_done_pt",   pt1,             64'h1);
        out_ready1 = 1'b1;
        @(negedge clk);
        check("r1_post_rdy",  64'(in_ready1),  64'd1);
        check("r1_post_ovld", 64'(out_valid1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
